// File: rtl/rvb_bitcnt_arb_pkg.sv
// Shared definitions for the two-channel bit-count front end.
// Insn field positions describe the packed {insn22, insn21, insn20, insn3} control word.
package rvb_bitcnt_arb_pkg;
   localparam int INSN3  = 0;
   localparam int INSN20 = 1;
   localparam int INSN21 = 2;
   localparam int INSN22 = 3;
   localparam int NCH    = 2;

   typedef logic tag_t;

   function automatic tag_t other_tag(input tag_t t);
      return tag_t'(~t);
   endfunction
endpackage

// File: rtl/rvb_bitcnt_arb_obuf.sv
// One-entry result buffer with valid/ready output; a load may coincide with a pop,
// in which case the entry stays full with the new data.
module rvb_bitcnt_arb_obuf #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            load,
   input  logic [XLEN-1:0] load_data,
   input  logic            ready,
   output logic            valid,
   output logic [XLEN-1:0] data,
   output logic            pop,
   output logic            can_load
);
   assign pop      = valid && ready;
   assign can_load = !valid || pop;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/rvb_bitcnt_arb.sv
// Round-robin front end sharing one combinational bit-count unit between two
// request channels: issue register feeds the unit, results are steered by tag.
module rvb_bitcnt_arb
   import rvb_bitcnt_arb_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            din0_valid,
   output logic            din0_ready,
   input  logic [XLEN-1:0] din0_rs1,
   input  logic [3:0]      din0_insn,
   input  logic            din1_valid,
   output logic            din1_ready,
   input  logic [XLEN-1:0] din1_rs1,
   input  logic [3:0]      din1_insn,
   output logic            dout0_valid,
   input  logic            dout0_ready,
   output logic [XLEN-1:0] dout0_rd,
   output logic            dout1_valid,
   input  logic            dout1_ready,
   output logic [XLEN-1:0] dout1_rd,
   output logic            unit_din_valid,
   input  logic            unit_din_ready,
   output logic [XLEN-1:0] unit_din_rs1,
   output logic [3:0]      unit_din_insn,
   input  logic            unit_dout_valid,
   output logic            unit_dout_ready,
   input  logic [XLEN-1:0] unit_dout_rd
);
   tag_t            prio;
   logic            ir_valid;
   tag_t            ir_tag;
   logic [XLEN-1:0] ir_rs1;
   logic [3:0]      ir_insn;

   logic [NCH-1:0]  ob_valid;
   logic [NCH-1:0]  ob_pop;
   logic [NCH-1:0]  ob_can_load;
   logic [NCH-1:0]  ob_load;
   logic [NCH-1:0]  out_ready;
   logic [XLEN-1:0] ob_rd [NCH];

   logic            grant0;
   logic            grant1;
   tag_t            grant_tag;
   logic            retire;
   logic            ir_free;
   logic            accept;

   // Unit handshake: a result is taken only if its destination buffer can absorb it.
   assign unit_din_valid  = ir_valid;
   assign unit_din_rs1    = ir_rs1;
   assign unit_din_insn   = ir_insn;
   assign unit_dout_ready = ir_valid && ob_can_load[ir_tag];
   assign retire          = ir_valid && unit_din_ready && unit_dout_valid && unit_dout_ready;

   // resetn gates ready so every output is low while reset is held.
   assign ir_free   = resetn && (!ir_valid || retire);
   assign grant0    = din0_valid && (!din1_valid || (prio == 1'b0));
   assign grant1    = din1_valid && (!din0_valid || (prio == 1'b1));
   assign grant_tag = tag_t'(grant1);
   assign accept    = ir_free && (grant0 || grant1);

   assign din0_ready = grant0 && ir_free;
   assign din1_ready = grant1 && ir_free;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ir_valid <= 1'b0;
         ir_tag   <= '0;
         ir_rs1   <= '0;
         ir_insn  <= '0;
         prio     <= '0;
      end else if (accept) begin
         ir_valid <= 1'b1;
         ir_tag   <= grant_tag;
         ir_rs1   <= grant1 ? din1_rs1 : din0_rs1;
         ir_insn  <= grant1 ? din1_insn : din0_insn;
         prio     <= other_tag(grant_tag);
      end else if (retire) begin
         ir_valid <= 1'b0;
      end
   end

   assign out_ready = {dout1_ready, dout0_ready};

   for (genvar k = 0; k < NCH; k++) begin : g_ob
      assign ob_load[k] = retire && (ir_tag == tag_t'(k));

      rvb_bitcnt_arb_obuf #(.XLEN(XLEN)) u_obuf (
         .clock     (clock),
         .resetn    (resetn),
         .load      (ob_load[k]),
         .load_data (unit_dout_rd),
         .ready     (out_ready[k]),
         .valid     (ob_valid[k]),
         .data      (ob_rd[k]),
         .pop       (ob_pop[k]),
         .can_load  (ob_can_load[k])
      );
   end

   assign dout0_valid = ob_valid[0];
   assign dout1_valid = ob_valid[1];
   assign dout0_rd    = ob_rd[0];
   assign dout1_rd    = ob_rd[1];
endmodule

// File: tb/tb_rvb_bitcnt_arb.sv
// Bench for rvb_bitcnt_arb: directed scenarios plus random traffic, with a
// behavioural bit-count unit and per-channel result queues as reference.
module tb_rvb_bitcnt_arb;
   logic        clock;
   logic        resetn;
   logic        din0_valid, din1_valid;
   logic        din0_ready, din1_ready;
   logic [63:0] din0_rs1, din1_rs1;
   logic [3:0]  din0_insn, din1_insn;
   logic        dout0_valid, dout1_valid;
   logic        dout0_ready, dout1_ready;
   logic [63:0] dout0_rd, dout1_rd;
   logic        unit_din_valid, unit_din_ready;
   logic [63:0] unit_din_rs1;
   logic [3:0]  unit_din_insn;
   logic        unit_dout_valid, unit_dout_ready;
   logic [63:0] unit_dout_rd;
   logic        stall;

   int tests = 0;
   int fails = 0;

   logic [63:0] q0[$];
   logic [63:0] q1[$];
   logic        exp_prio = 1'b0;

   logic [3:0] ops [8] = '{4'b0000, 4'b0010, 4'b0100, 4'b0001,
                           4'b0011, 4'b0101, 4'b1000, 4'b1010};

   // Reference bit-count unit: {insn22,insn21,insn20,insn3}; insn3 selects 32-bit form.
   function automatic logic [63:0] bitcnt_ref(input logic [63:0] rs1, input logic [3:0] insn);
      int  w;
      int  n;
      logic done;
      if (insn[3]) begin
         if (insn[1]) return {{48{rs1[15]}}, rs1[15:0]};
         return {{56{rs1[7]}}, rs1[7:0]};
      end
      w = insn[0] ? 32 : 64;
      n = 0;
      done = 1'b0;
      case (insn[2:1])
         2'b00: for (int i = w - 1; i >= 0; i--) begin
                   if (!done) begin
                      if (rs1[i]) done = 1'b1;
                      else n++;
                   end
                end
         2'b01: for (int i = 0; i < w; i++) begin
                   if (!done) begin
                      if (rs1[i]) done = 1'b1;
                      else n++;
                   end
                end
         default: for (int i = 0; i < w; i++) if (rs1[i]) n++;
      endcase
      return 64'(n);
   endfunction

   assign unit_din_ready  = !stall;
   assign unit_dout_valid = unit_din_valid && !stall;
   assign unit_dout_rd    = bitcnt_ref(unit_din_rs1, unit_din_insn);

   rvb_bitcnt_arb #(.XLEN(64)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .din0_valid      (din0_valid),
      .din0_ready      (din0_ready),
      .din0_rs1        (din0_rs1),
      .din0_insn       (din0_insn),
      .din1_valid      (din1_valid),
      .din1_ready      (din1_ready),
      .din1_rs1        (din1_rs1),
      .din1_insn       (din1_insn),
      .dout0_valid     (dout0_valid),
      .dout0_ready     (dout0_ready),
      .dout0_rd        (dout0_rd),
      .dout1_valid     (dout1_valid),
      .dout1_ready     (dout1_ready),
      .dout1_rd        (dout1_rd),
      .unit_din_valid  (unit_din_valid),
      .unit_din_ready  (unit_din_ready),
      .unit_din_rs1    (unit_din_rs1),
      .unit_din_insn   (unit_din_insn),
      .unit_dout_valid (unit_dout_valid),
      .unit_dout_ready (unit_dout_ready),
      .unit_dout_rd    (unit_dout_rd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard, arbitration rule and output stability, sampled on the falling edge.
   initial begin
      logic        hold0, hold1;
      logic [63:0] held0, held1;
      hold0 = 1'b0;
      hold1 = 1'b0;
      held0 = '0;
      held1 = '0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            q0.delete();
            q1.delete();
            exp_prio = 1'b0;
            hold0 = 1'b0;
            hold1 = 1'b0;
         end else begin
            check("single_grant", din0_ready && din1_ready, 0);
            if (din0_valid && din1_valid && (din0_ready || din1_ready))
               check("rr_grant_ch1", din1_ready, exp_prio);
            if (hold0) begin
               check("hold0_valid", dout0_valid, 1);
               check("hold0_rd", dout0_rd, held0);
            end
            if (hold1) begin
               check("hold1_valid", dout1_valid, 1);
               check("hold1_rd", dout1_rd, held1);
            end
            if (din0_valid && din0_ready) begin
               q0.push_back(bitcnt_ref(din0_rs1, din0_insn));
               exp_prio = 1'b1;
            end
            if (din1_valid && din1_ready) begin
               q1.push_back(bitcnt_ref(din1_rs1, din1_insn));
               exp_prio = 1'b0;
            end
            if (dout0_valid && dout0_ready) begin
               check("pop0_expected", q0.size() != 0, 1);
               if (q0.size() != 0) check("pop0_rd", dout0_rd, q0.pop_front());
            end
            if (dout1_valid && dout1_ready) begin
               check("pop1_expected", q1.size() != 0, 1);
               if (q1.size() != 0) check("pop1_rd", dout1_rd, q1.pop_front());
            end
            hold0 = dout0_valid && !dout0_ready;
            hold1 = dout1_valid && !dout1_ready;
            held0 = dout0_rd;
            held1 = dout1_rd;
         end
      end
   end

   initial begin
      int sent;
      int pops;
      int n;
      logic acc;

      resetn = 1'b0;
      stall = 1'b0;
      din0_valid = 1'b1; din0_rs1 = 64'd1; din0_insn = 4'b0000;
      din1_valid = 1'b0; din1_rs1 = '0;    din1_insn = 4'b0000;
      dout0_ready = 1'b1; dout1_ready = 1'b1;
      repeat (2) step();
      check("rst_din0_ready", din0_ready, 0);
      check("rst_dout0_valid", dout0_valid, 0);
      check("rst_dout1_valid", dout1_valid, 0);
      check("rst_unit_din_valid", unit_din_valid, 0);
      check("rst_unit_dout_ready", unit_dout_ready, 0);
      check("rst_dout0_rd", dout0_rd, 0);
      din0_valid = 1'b0;
      resetn = 1'b1;
      step();

      // Both channels contend every cycle with PCNT: grants alternate from ch0.
      din0_valid = 1'b1; din0_rs1 = 64'hFF; din0_insn = 4'b0100;
      din1_valid = 1'b1; din1_rs1 = 64'hF;  din1_insn = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("alt_din0_ready", din0_ready, (i % 2) == 0);
         check("alt_din1_ready", din1_ready, (i % 2) == 1);
         if (i == 2) begin
            check("alt_dout0_valid", dout0_valid, 1);
            check("alt_dout0_rd", dout0_rd, 64'd8);
         end
         if (i == 3) begin
            check("alt_dout1_valid", dout1_valid, 1);
            check("alt_dout1_rd", dout1_rd, 64'd4);
         end
         step();
      end
      din0_valid = 1'b0; din1_valid = 1'b0;
      repeat (3) step();

      // CLZ on ch0: two-cycle latency, ch1 stays quiet.
      din0_valid = 1'b1; din0_rs1 = 64'd1; din0_insn = 4'b0000;
      #1;
      check("clz_din0_ready", din0_ready, 1);
      step();
      din0_valid = 1'b0;
      check("clz_lat1_valid", dout0_valid, 0);
      step();
      check("clz_dout0_valid", dout0_valid, 1);
      check("clz_dout0_rd", dout0_rd, 64'd63);
      check("clz_dout1_valid", dout1_valid, 0);
      step();
      check("clz_popped", dout0_valid, 0);

      // CTZ pair on ch1 with a stalled consumer blocks ch0 behind the IR.
      dout1_ready = 1'b0;
      din1_valid = 1'b1; din1_rs1 = 64'h10; din1_insn = 4'b0010;
      #1;
      check("ctz_a_ready", din1_ready, 1);
      step();
      check("ctz_b_ready", din1_ready, 1);
      step();
      din1_valid = 1'b0;
      din0_valid = 1'b1; din0_rs1 = 64'd1; din0_insn = 4'b0000;
      #1;
      check("hol_din0_ready", din0_ready, 0);
      check("hol_dout1_valid", dout1_valid, 1);
      check("hol_dout1_rd", dout1_rd, 64'd4);
      step();
      check("hol_din0_ready2", din0_ready, 0);
      dout1_ready = 1'b1;
      #1;
      check("hol_release_din0", din0_ready, 1);
      step();
      din0_valid = 1'b0;
      check("hol_second_valid", dout1_valid, 1);
      check("hol_second_rd", dout1_rd, 64'd4);
      step();
      check("hol_ch0_valid", dout0_valid, 1);
      check("hol_ch0_rd", dout0_rd, 64'd63);
      step();

      // SEXT.B on ch0 with toggling consumer ready.
      sent = 0;
      pops = 0;
      din0_rs1 = 64'h80; din0_insn = 4'b1000;
      for (int i = 0; i < 16; i++) begin
         din0_valid = (sent < 4);
         dout0_ready = (i % 2) == 1;
         #1;
         acc = din0_valid && din0_ready;
         if (dout0_valid) check("sext_rd", dout0_rd, 64'hFFFF_FFFF_FFFF_FF80);
         if (dout0_valid && dout0_ready) pops++;
         step();
         if (acc) sent++;
      end
      din0_valid = 1'b0;
      dout0_ready = 1'b1;
      check("sext_sent", sent, 4);
      check("sext_pops", pops, 4);

      // Asynchronous reset with IR and OB0 both occupied.
      dout0_ready = 1'b0;
      din0_valid = 1'b1; din0_rs1 = 64'h3; din0_insn = 4'b0000;
      step();
      step();
      din0_valid = 1'b0;
      #1;
      check("prerst_dout0_valid", dout0_valid, 1);
      check("prerst_ir_valid", unit_din_valid, 1);
      #1;
      resetn = 1'b0;
      #1;
      check("arst_dout0_valid", dout0_valid, 0);
      check("arst_dout1_valid", dout1_valid, 0);
      check("arst_unit_din_valid", unit_din_valid, 0);
      check("arst_dout0_rd", dout0_rd, 0);
      check("arst_unit_din_rs1", unit_din_rs1, 0);
      step();
      resetn = 1'b1;
      dout0_ready = 1'b1;
      din0_valid = 1'b1; din0_rs1 = 64'h5; din0_insn = 4'b0100;
      din1_valid = 1'b1; din1_rs1 = 64'h7; din1_insn = 4'b0100;
      #1;
      check("post_rst_din0_ready", din0_ready, 1);
      check("post_rst_din1_ready", din1_ready, 0);
      step();
      din0_valid = 1'b0; din1_valid = 1'b0;
      repeat (3) step();

      // Ch1 streaming: one accept per cycle, then prio points at ch0.
      din1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         din1_rs1 = {$urandom, $urandom};
         din1_insn = ops[$urandom_range(7)];
         #1;
         check("stream_din1_ready", din1_ready, 1);
         step();
      end
      din0_valid = 1'b1; din0_rs1 = 64'h1; din0_insn = 4'b0000;
      #1;
      check("stream_prio_ch0", din0_ready, 1);
      step();
      din0_valid = 1'b0; din1_valid = 1'b0;

      // Random traffic with unit stalls and consumer back-pressure.
      for (int i = 0; i < 400; i++) begin
         din0_valid  = ($urandom_range(3) != 0);
         din1_valid  = ($urandom_range(3) != 0);
         din0_rs1    = {$urandom, $urandom};
         din1_rs1    = {$urandom, $urandom};
         din0_insn   = ops[$urandom_range(7)];
         din1_insn   = ops[$urandom_range(7)];
         dout0_ready = ($urandom_range(2) != 0);
         dout1_ready = ($urandom_range(2) != 0);
         stall       = ($urandom_range(4) == 0);
         step();
      end
      din0_valid = 1'b0; din1_valid = 1'b0;
      dout0_ready = 1'b1; dout1_ready = 1'b1;
      stall = 1'b0;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || dout0_valid || dout1_valid) && n < 100) begin
         step();
         n++;
      end
      check("drain_in_time", n < 100, 1);
      check("drain_q0_empty", q0.size(), 0);
      check("drain_q1_empty", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
